// File: rtl/delayfall_sync_if.sv
// rtl/delayfall_sync_if.sv - logic-level signals of the falling-edge delay cell
interface delayfall_sync_if;
  logic i;
  logic o;
  logic busy;
  logic fall;

  modport master (output i, input o, input busy, input fall);
  modport slave  (input i, output o, output busy, output fall);
endinterface

// File: rtl/delayfall_sync.sv
// rtl/delayfall_sync.sv - clocked falling-edge delay cell
// Synchronises i, passes rises through, and holds o high DELAY_CYC cycles past a fall.
module delayfall_sync #(
  parameter int DELAY_CYC = 5,
  parameter int CNT_W     = 8
) (
  input logic             CELCLK,
  input logic             CELRSTN,
  input logic             CELV,
  input logic             CELG,
  input logic             CELSUB,
  delayfall_sync_if.slave bus
);

  generate
    if (DELAY_CYC < 1 || 64'(DELAY_CYC) > (64'(1) << CNT_W)) begin : g_bad_delay
      $fatal(1, "delayfall_sync: DELAY_CYC out of range for CNT_W");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_LOW  = 2'd0,
    ST_HIGH = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DELAY_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Supply pins exist only so the symbol matches the analog delay cells.
  wire unused_supply = &{1'b0, CELV, CELG, CELSUB};

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             s1, s2;
  logic             o_q, busy_q, fall_q;
  logic             o_nxt, busy_nxt, fall_nxt;

  always_ff @(posedge CELCLK or negedge CELRSTN) begin
    if (!CELRSTN) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      state  <= ST_LOW;
      cnt    <= '0;
      o_q    <= 1'b0;
      busy_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1     <= bus.i;
      s2     <= s1;
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      o_q    <= o_nxt;
      busy_q <= busy_nxt;
      fall_q <= fall_nxt;
    end
  end

  // A re-rise in WAIT is checked before expiry so o never dips on a collision.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    fall_nxt  = 1'b0;
    case (state)
      ST_LOW: begin
        if (s2) state_nxt = ST_HIGH;
      end
      ST_HIGH: begin
        if (!s2) begin
          state_nxt = ST_WAIT;
          cnt_nxt   = CNT_LOAD;
        end
      end
      ST_WAIT: begin
        if (s2) begin
          state_nxt = ST_HIGH;
          cnt_nxt   = '0;
        end else if (cnt == '0) begin
          state_nxt = ST_LOW;
          fall_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      default: begin
        state_nxt = ST_LOW;
        cnt_nxt   = '0;
      end
    endcase
    o_nxt    = (state_nxt != ST_LOW);
    busy_nxt = (state_nxt == ST_WAIT);
  end

  assign bus.o    = o_q;
  assign bus.busy = busy_q;
  assign bus.fall = fall_q;

endmodule

// File: tb/tb_delayfall_sync.sv
// tb/tb_delayfall_sync.sv - directed bench for delayfall_sync at DELAY_CYC 5, 1 and 256
module tb_delayfall_sync;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  delayfall_sync_if bus5 ();
  delayfall_sync_if bus1 ();
  delayfall_sync_if bus256 ();

  delayfall_sync #(.DELAY_CYC(5), .CNT_W(8)) dut5 (
    .CELCLK(clk), .CELRSTN(rst_n), .CELV(1'b1), .CELG(1'b0), .CELSUB(1'b0), .bus(bus5.slave)
  );
  delayfall_sync #(.DELAY_CYC(1), .CNT_W(8)) dut1 (
    .CELCLK(clk), .CELRSTN(rst_n), .CELV(1'b1), .CELG(1'b0), .CELSUB(1'b0), .bus(bus1.slave)
  );
  delayfall_sync #(.DELAY_CYC(256), .CNT_W(8)) dut256 (
    .CELCLK(clk), .CELRSTN(rst_n), .CELV(1'b1), .CELG(1'b0), .CELSUB(1'b0), .bus(bus256.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus5.i = 1'b0;
    bus1.i = 1'b0;
    bus256.i = 1'b0;
    for (int t = 0; t < 6; t++) begin
      bus5.i = t[0];
      tick();
      checks++;
      if (bus5.o !== 1'b0 || bus5.busy !== 1'b0 || bus5.fall !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold t=%0d: o=%b busy=%b fall=%b, required 0 0 0", t, bus5.o, bus5.busy, bus5.fall);
      end
    end
    bus5.i = 1'b1;
    rst_n = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      tick();
      checks++;
      if (bus5.o !== (t >= 3) || bus5.busy !== 1'b0 || bus5.fall !== 1'b0) begin
        errors++;
        $display("FAIL reset_release_rise t=%0d: o=%b busy=%b fall=%b, required %b 0 0", t, bus5.o, bus5.busy, bus5.fall, (t >= 3));
      end
    end
  endtask

  task automatic test_basic_fall();
    bus5.i = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      checks++;
      if (bus5.o !== (t <= 7) || bus5.busy !== (t >= 3 && t <= 7) || bus5.fall !== (t == 8)) begin
        errors++;
        $display("FAIL basic_fall t=%0d: o=%b busy=%b fall=%b, required %b %b %b", t, bus5.o, bus5.busy, bus5.fall,
                 (t <= 7), (t >= 3 && t <= 7), (t == 8));
      end
    end
  endtask

  task automatic test_abort();
    bus5.i = 1'b1;
    for (int t = 1; t <= 3; t++) tick();
    checks++;
    if (bus5.o !== 1'b1) begin
      errors++;
      $display("FAIL abort_setup: o=%b, required 1", bus5.o);
    end
    bus5.i = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      if (t == 4) bus5.i = 1'b1;
      tick();
      checks++;
      if (bus5.o !== 1'b1 || bus5.busy !== (t >= 3 && t <= 5) || bus5.fall !== 1'b0) begin
        errors++;
        $display("FAIL abort t=%0d: o=%b busy=%b fall=%b, required 1 %b 0", t, bus5.o, bus5.busy, bus5.fall, (t >= 3 && t <= 5));
      end
    end
    bus5.i = 1'b0;
    for (int t = 1; t <= 9; t++) begin
      tick();
      checks++;
      if (bus5.o !== (t <= 7) || bus5.busy !== (t >= 3 && t <= 7) || bus5.fall !== (t == 8)) begin
        errors++;
        $display("FAIL abort_refall t=%0d: o=%b busy=%b fall=%b, required %b %b %b", t, bus5.o, bus5.busy, bus5.fall,
                 (t <= 7), (t >= 3 && t <= 7), (t == 8));
      end
    end
  endtask

  task automatic test_collision();
    bus5.i = 1'b1;
    for (int t = 1; t <= 3; t++) tick();
    checks++;
    if (bus5.o !== 1'b1) begin
      errors++;
      $display("FAIL collision_setup: o=%b, required 1", bus5.o);
    end
    bus5.i = 1'b0;
    // The re-rise reaches s2 on the very edge where cnt has just reached 0.
    for (int t = 1; t <= 10; t++) begin
      if (t == 6) bus5.i = 1'b1;
      tick();
      checks++;
      if (bus5.o !== 1'b1 || bus5.busy !== (t >= 3 && t <= 7) || bus5.fall !== 1'b0) begin
        errors++;
        $display("FAIL collision t=%0d: o=%b busy=%b fall=%b, required 1 %b 0", t, bus5.o, bus5.busy, bus5.fall, (t >= 3 && t <= 7));
      end
    end
  endtask

  task automatic test_delay1();
    bus1.i = 1'b1;
    for (int t = 1; t <= 3; t++) tick();
    checks++;
    if (bus1.o !== 1'b1) begin
      errors++;
      $display("FAIL delay1_setup: o=%b, required 1", bus1.o);
    end
    bus1.i = 1'b0;
    for (int t = 1; t <= 6; t++) begin
      tick();
      checks++;
      if (bus1.o !== (t <= 3) || bus1.busy !== (t == 3) || bus1.fall !== (t == 4)) begin
        errors++;
        $display("FAIL delay1 t=%0d: o=%b busy=%b fall=%b, required %b %b %b", t, bus1.o, bus1.busy, bus1.fall,
                 (t <= 3), (t == 3), (t == 4));
      end
    end
  endtask

  task automatic test_delay256();
    bus256.i = 1'b1;
    for (int t = 1; t <= 3; t++) tick();
    checks++;
    if (bus256.o !== 1'b1) begin
      errors++;
      $display("FAIL delay256_setup: o=%b, required 1", bus256.o);
    end
    bus256.i = 1'b0;
    for (int t = 1; t <= 262; t++) begin
      tick();
      checks++;
      if (bus256.o !== (t <= 258) || bus256.busy !== (t >= 3 && t <= 258) || bus256.fall !== (t == 259)) begin
        errors++;
        $display("FAIL delay256 t=%0d: o=%b busy=%b fall=%b, required %b %b %b", t, bus256.o, bus256.busy, bus256.fall,
                 (t <= 258), (t >= 3 && t <= 258), (t == 259));
      end
    end
  endtask

  task automatic test_mid_reset();
    bus5.i = 1'b1;
    for (int t = 1; t <= 3; t++) tick();
    bus5.i = 1'b0;
    for (int t = 1; t <= 5; t++) tick();
    checks++;
    if (bus5.o !== 1'b1 || bus5.busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_setup: o=%b busy=%b, required 1 1", bus5.o, bus5.busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus5.o !== 1'b0 || bus5.busy !== 1'b0 || bus5.fall !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_async: o=%b busy=%b fall=%b, required 0 0 0", bus5.o, bus5.busy, bus5.fall);
    end
    tick();
    rst_n = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      tick();
      checks++;
      if (bus5.o !== 1'b0 || bus5.busy !== 1'b0 || bus5.fall !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_after t=%0d: o=%b busy=%b fall=%b, required 0 0 0", t, bus5.o, bus5.busy, bus5.fall);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic_fall();
    test_abort();
    test_collision();
    test_delay1();
    test_delay256();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
